// File: rtl/int_to_float.sv
// int_to_float: four-stage pipelined signed-integer to float converter with valid/ready stall.
// Define INT_TO_FLOAT_ROUND_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module int_to_float #(
  parameter int MANTISSA_SIZE        = 23,
  parameter int EXPONENT_SIZE        = 8,
  parameter int INT_SIZE             = 32,
  parameter int EXPONENT_BIAS_OFFSET = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [INT_SIZE-1:0]                  in,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [EXPONENT_SIZE+MANTISSA_SIZE:0] out
);

  localparam int LZ_W  = $clog2(INT_SIZE);
  localparam int EW    = EXPONENT_SIZE + 2;
  localparam int FW    = 1 + EXPONENT_SIZE + MANTISSA_SIZE;
  localparam int LOW_W = INT_SIZE - 1 - MANTISSA_SIZE;
  // A positive offset scales the result by 2^-offset, matching the float-to-int stage.
  localparam int BIAS  = (2 ** (EXPONENT_SIZE - 1)) - 1 - EXPONENT_BIAS_OFFSET;

  localparam logic signed [EW-1:0] EXP_INF  = EW'((2 ** EXPONENT_SIZE) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = {EW{1'b0}};
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);

  logic advance_s;

  logic                s1_valid_r;
  logic                s1_sign_r;
  logic                s1_zero_r;
  logic [INT_SIZE-1:0] s1_mag_r;

  logic                s2_valid_r;
  logic                s2_sign_r;
  logic                s2_zero_r;
  logic [INT_SIZE-1:0] s2_mag_r;
  logic [LZ_W-1:0]     s2_lz_r;

  logic                 s3_valid_r;
  logic                 s3_sign_r;
  logic                 s3_zero_r;
  logic [INT_SIZE-1:0]  s3_norm_r;
  logic signed [EW-1:0] s3_exp_r;

  logic [INT_SIZE-1:0]      in_mag_s;
  logic                     in_zero_s;
  logic [LZ_W-1:0]          lz_s;
  logic [INT_SIZE-1:0]      norm_s;
  logic signed [EW-1:0]     exp_s;
  logic [MANTISSA_SIZE-1:0] mant_trunc_s;
  logic [MANTISSA_SIZE-1:0] mant_s;
  logic signed [EW-1:0]     exp_rnd_s;
  logic [FW-1:0]            packed_s;

`ifdef INT_TO_FLOAT_ROUND_EN
  localparam logic [INT_SIZE-1:0] STICKY_MASK =
    (INT_SIZE'(1) << (LOW_W - 1)) - INT_SIZE'(1);
  logic                   guard_s;
  logic                   sticky_s;
  logic [MANTISSA_SIZE:0] mant_inc_s;
  logic                   norm_unused_s;
  assign norm_unused_s = s3_norm_r[INT_SIZE-1];
`else
  logic norm_unused_s;
  assign norm_unused_s = ^{s3_norm_r[INT_SIZE-1], s3_norm_r[LOW_W-1:0]};
`endif

  // The whole pipeline moves when the output slot is empty or being consumed.
  always_comb begin
    advance_s = !out_valid || out_ready;
    in_ready  = advance_s;
  end

  // Stage 1 combinational: magnitude and zero detect (most-negative maps to 2^(INT_SIZE-1)).
  always_comb begin
    in_zero_s = (in == {INT_SIZE{1'b0}});
    if (in[INT_SIZE-1]) begin
      in_mag_s = -in;
    end else begin
      in_mag_s = in;
    end
  end

  // Stage 1 register: sign, magnitude and zero flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_sign_r  <= 1'b0;
      s1_zero_r  <= 1'b0;
      s1_mag_r   <= {INT_SIZE{1'b0}};
    end else if (advance_s) begin
      s1_valid_r <= in_valid;
      s1_sign_r  <= in[INT_SIZE-1];
      s1_zero_r  <= in_zero_s;
      s1_mag_r   <= in_mag_s;
    end
  end

  // Stage 2 combinational: leading-zero count, highest set bit wins.
  always_comb begin
    lz_s = LZ_W'(INT_SIZE - 1);
    for (int i = 0; i < INT_SIZE; i++) begin
      if (s1_mag_r[i]) begin
        lz_s = LZ_W'(INT_SIZE - 1 - i);
      end else begin
        lz_s = lz_s;
      end
    end
  end

  // Stage 2 register: carry magnitude alongside its leading-zero count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_r <= 1'b0;
      s2_sign_r  <= 1'b0;
      s2_zero_r  <= 1'b0;
      s2_mag_r   <= {INT_SIZE{1'b0}};
      s2_lz_r    <= {LZ_W{1'b0}};
    end else if (advance_s) begin
      s2_valid_r <= s1_valid_r;
      s2_sign_r  <= s1_sign_r;
      s2_zero_r  <= s1_zero_r;
      s2_mag_r   <= s1_mag_r;
      s2_lz_r    <= lz_s;
    end
  end

  // Stage 3 combinational: normalise so the MSB is the hidden bit; biased exponent.
  always_comb begin
    norm_s = s2_mag_r << s2_lz_r;
    exp_s  = EW'(INT_SIZE - 1 - int'(s2_lz_r) + BIAS);
  end

  // Stage 3 register: normalised significand and signed exponent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_valid_r <= 1'b0;
      s3_sign_r  <= 1'b0;
      s3_zero_r  <= 1'b0;
      s3_norm_r  <= {INT_SIZE{1'b0}};
      s3_exp_r   <= EXP_ZERO;
    end else if (advance_s) begin
      s3_valid_r <= s2_valid_r;
      s3_sign_r  <= s2_sign_r;
      s3_zero_r  <= s2_zero_r;
      s3_norm_r  <= norm_s;
      s3_exp_r   <= exp_s;
    end
  end

  // Stage 4 combinational: mantissa extraction and optional round-to-nearest-even.
  always_comb begin
    mant_trunc_s = s3_norm_r[INT_SIZE-2 -: MANTISSA_SIZE];
`ifdef INT_TO_FLOAT_ROUND_EN
    guard_s    = s3_norm_r[LOW_W-1];
    sticky_s   = |(s3_norm_r & STICKY_MASK);
    mant_inc_s = {1'b0, mant_trunc_s} + {{MANTISSA_SIZE{1'b0}}, 1'b1};
    if (guard_s && (sticky_s || mant_trunc_s[0])) begin
      mant_s = mant_inc_s[MANTISSA_SIZE-1:0];
      if (mant_inc_s[MANTISSA_SIZE]) begin
        exp_rnd_s = s3_exp_r + EXP_ONE;
      end else begin
        exp_rnd_s = s3_exp_r;
      end
    end else begin
      mant_s    = mant_trunc_s;
      exp_rnd_s = s3_exp_r;
    end
`else
    mant_s    = mant_trunc_s;
    exp_rnd_s = s3_exp_r;
`endif
  end

  // Stage 4 packing: zero, overflow to infinity, flush-to-zero underflow, normal.
  always_comb begin
    if (s3_zero_r) begin
      packed_s = {FW{1'b0}};
    end else if (exp_rnd_s >= EXP_INF) begin
      packed_s = {s3_sign_r, {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};
    end else if (exp_rnd_s <= EXP_ZERO) begin
      packed_s = {s3_sign_r, {(FW-1){1'b0}}};
    end else begin
      packed_s = {s3_sign_r, exp_rnd_s[EXPONENT_SIZE-1:0], mant_s};
    end
  end

  // Output register: holds while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out       <= {FW{1'b0}};
    end else if (advance_s) begin
      out_valid <= s3_valid_r;
      out       <= packed_s;
    end
  end

endmodule

// File: tb/tb_int_to_float.sv
// Self-checking bench for int_to_float: directed vectors, random streams with backpressure,
// and asynchronous reset, checked against an arithmetic reference model and a FIFO scoreboard.
module tb_int_to_float;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_m1;
  logic [31:0] out_p1;
  logic        out_valid_m1;
  logic        out_valid_p1;
  logic        rdy_m1_unused;
  logic        rdy_p1_unused;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] q_val[$];
  logic [31:0] q_exp[$];
  int          q_acc[$];

  logic        lat_check    = 1'b0;
  logic        stalled_prev = 1'b0;
  logic [31:0] prev_out     = 32'd0;

  always #5 clk = ~clk;

  int_to_float dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out(out_data)
  );

  int_to_float #(.EXPONENT_BIAS_OFFSET(-1)) dut_m1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_m1_unused), .in(in_data),
    .out_valid(out_valid_m1), .out_ready(out_ready), .out(out_m1)
  );

  int_to_float #(.EXPONENT_BIAS_OFFSET(1)) dut_p1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_p1_unused), .in(in_data),
    .out_valid(out_valid_p1), .out_ready(out_ready), .out(out_p1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Value-level model: find floor(log2|v|), scale the fraction to 23 bits, optionally round.
  function automatic logic [31:0] ref_conv(input logic [31:0] v, input int off);
    longint mag;
    longint frac;
    longint mant;
    int     e;
    int     bexp;
    logic   s;
`ifdef INT_TO_FLOAT_ROUND_EN
    longint rem;
    longint half;
`endif
    if (v == 32'd0) return 32'd0;
    s   = v[31];
    mag = longint'($signed(v));
    if (mag < 64'sd0) mag = -mag;
    e = 0;
    while ((mag >>> (e + 1)) != 64'sd0) e++;
    frac = mag - (64'sd1 <<< e);
    if (e <= 23) begin
      mant = frac <<< (23 - e);
    end else begin
      mant = frac >>> (e - 23);
`ifdef INT_TO_FLOAT_ROUND_EN
      rem  = frac - (mant <<< (e - 23));
      half = 64'sd1 <<< (e - 24);
      if (rem > half || (rem == half && mant[0])) mant = mant + 64'sd1;
`endif
    end
    if (mant == (64'sd1 <<< 23)) begin
      mant = 64'sd0;
      e++;
    end
    bexp = e + 127 - off;
    return {s, bexp[7:0], mant[22:0]};
  endfunction

  // One clock: drive inputs, score the output side and the handshake, then advance.
  task automatic cycle(input logic v, input logic [31:0] d, input logic ordy,
                       input logic [31:0] expv, output logic acc);
    logic [31:0] ev;
    logic [31:0] vv;
    int          a;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || ordy)});
    if (out_valid) begin
      if (stalled_prev) check("hold", out_data, prev_out);
      if (ordy) begin
        if (q_exp.size() == 0) begin
          check("spurious_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          ev = q_exp.pop_front();
          vv = q_val.pop_front();
          a  = q_acc.pop_front();
          check("out", out_data, ev);
          check("valid_m1", {30'd0, out_valid_m1, out_valid_p1}, 32'd3);
          check("out_bias_m1", out_m1, ref_conv(vv, -1));
          check("out_bias_p1", out_p1, ref_conv(vv, 1));
          if (lat_check) check("latency", cyc - a, 32'd4);
        end
      end
    end
    stalled_prev = out_valid && !ordy;
    prev_out     = out_data;
    acc          = v && in_ready;
    if (acc) begin
      q_val.push_back(d);
      q_exp.push_back(expv);
      q_acc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    logic acc;
    for (int k = 0; k < 40 && q_exp.size() != 0; k++) cycle(1'b0, 32'd0, 1'b1, 32'd0, acc);
    for (int k = 0; k < 4; k++) cycle(1'b0, 32'd0, 1'b1, 32'd0, acc);
    check("drain_empty", q_exp.size(), 32'd0);
  endtask

  initial begin
    logic        acc;
    logic        ordy;
    logic [31:0] val;
    int          stall_at;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b1;
    #2;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out", out_data, 32'd0);
    #10;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back directed vectors at full throughput with latency checks.
    lat_check = 1'b1;
    cycle(1'b1, 32'd1, 1'b1, 32'h3F800000, acc);
    cycle(1'b1, 32'd0, 1'b1, 32'h00000000, acc);
    cycle(1'b1, 32'd1, 1'b1, 32'h3F800000, acc);
    cycle(1'b1, 32'd2, 1'b1, 32'h40000000, acc);
    cycle(1'b1, 32'hFFFFFFFF, 1'b1, 32'hBF800000, acc);
    cycle(1'b1, 32'h80000000, 1'b1, 32'hCF000000, acc);
    cycle(1'b1, 32'hFFFFFFFD, 1'b1, 32'hC0400000, acc);
    cycle(1'b1, 32'd16777217, 1'b1, 32'h4B800000, acc);
`ifdef INT_TO_FLOAT_ROUND_EN
    cycle(1'b1, 32'd16777219, 1'b1, 32'h4B800002, acc);
    cycle(1'b1, 32'h7FFFFFFF, 1'b1, 32'h4F000000, acc);
`else
    cycle(1'b1, 32'd16777219, 1'b1, 32'h4B800001, acc);
    cycle(1'b1, 32'h7FFFFFFF, 1'b1, 32'h4EFFFFFF, acc);
`endif
    cycle(1'b1, 32'd3, 1'b1, 32'h40400000, acc);
    drain();

    // Ten random words with a five-cycle consumer stall in the middle.
    lat_check = 1'b0;
    stall_at  = 1000000;
    for (int i = 0; i < 10; i++) begin
      val = $urandom;
      if (i == 6) stall_at = cyc;
      acc = 1'b0;
      for (int k = 0; k < 20 && !acc; k++) begin
        ordy = !(cyc >= stall_at && cyc < stall_at + 5);
        cycle(1'b1, val, ordy, ref_conv(val, 0), acc);
      end
      check("accepted", {31'd0, acc}, 32'd1);
    end
    drain();

    // Longer random stream with random backpressure and input gaps.
    for (int i = 0; i < 40; i++) begin
      val = $urandom;
      if (i % 4 == 0) val = val >> $urandom_range(0, 31);
      acc = 1'b0;
      for (int k = 0; k < 50 && !acc; k++) begin
        ordy = ($urandom_range(0, 3) != 0);
        cycle(($urandom_range(0, 4) != 0), val, ordy, ref_conv(val, 0), acc);
      end
      check("accepted_rand", {31'd0, acc}, 32'd1);
    end
    drain();

    // Asynchronous reset with one result at the output and three in flight.
    lat_check = 1'b1;
    for (int i = 0; i < 4; i++) begin
      val = $urandom;
      cycle(1'b1, val, 1'b1, ref_conv(val, 0), acc);
    end
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_reset_out", out_data, 32'd0);
    q_val.delete();
    q_exp.delete();
    q_acc.delete();
    stalled_prev = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1'b1, 32'd5, 1'b1, 32'h40A00000, acc);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
